// File: rtl/xbus_pkg.sv
// Shared Xbus definitions used by the arbiter and its round-robin picker.
//   XBUS_ADDR_W / XBUS_DATA_W : slave address and data widths
//   xbus_state_e              : arbiter state encoding (IDLE, REQ, WAIT)
//   DECODE_MISS_LIMIT         : consecutive unclaimed REQ cycles before an early timeout
//   tmo_term()                : terminal count of a TMO_W-bit timeout counter
package xbus_pkg;

    localparam int XBUS_ADDR_W       = 22;
    localparam int XBUS_DATA_W       = 32;
    localparam int DECODE_MISS_LIMIT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } xbus_state_e;

    function automatic int tmo_term(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req  : per-master request vector
//   last : index of the most recently completed owner
//   gnt  : one-hot winner, the first requester found searching upward from
//          last+1 with wrap-around; all zero when nothing is requesting
module rr_pick #(
    parameter int NREQ  = 3,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic [NREQ-1:0]  gnt
);

    logic found;

    // Outer loop walks the search distance 1..NREQ from last; the inner loop
    // keeps every bit select constant so the whole thing unrolls cleanly.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!found && req[j] && (((int'(last) + i) % NREQ) == j)) begin
                    gnt[j] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/xbus_arbiter.sv
// Round-robin arbiter sharing one Xbus slave between NREQ masters.
// One four-phase transaction at a time: IDLE -> REQ (slave request presented)
// -> WAIT (m_ack held until the owner drops m_req) -> IDLE.
// Handshake: a master raises m_req and holds it until it sees m_ack; it then
// drops m_req, which ends the transaction. Dropping m_req before m_ack aborts
// the transaction without an acknowledge. The slave sees s_req high only in
// REQ and completes with a single-cycle s_ack.
//   clk, reset_n         : clock, asynchronous active-low reset
//   m_req/m_write        : per-master request and direction (1 = write)
//   m_addr/m_wdata       : per-master address and write data, packed by index
//   m_ack                : one-hot done to the owner (WAIT only)
//   m_timedout           : last completed transaction ended by timeout
//   m_rdata              : registered read data, shared by all masters
//   grant                : one-hot current owner, zero when idle
//   s_req/s_write/s_addr/s_wdata : request to the slave
//   s_rdata/s_ack/s_decode       : slave response and address claim
//   state_dbg            : current arbiter state
module xbus_arbiter
    import xbus_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int TMO_W = 6
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NREQ-1:0]             m_req,
    input  logic [NREQ-1:0]             m_write,
    input  logic [NREQ*XBUS_ADDR_W-1:0] m_addr,
    input  logic [NREQ*XBUS_DATA_W-1:0] m_wdata,
    output logic [NREQ-1:0]             m_ack,
    output logic                        m_timedout,
    output logic [XBUS_DATA_W-1:0]      m_rdata,
    output logic [NREQ-1:0]             grant,
    output logic                        s_req,
    output logic                        s_write,
    output logic [XBUS_ADDR_W-1:0]      s_addr,
    output logic [XBUS_DATA_W-1:0]      s_wdata,
    input  logic [XBUS_DATA_W-1:0]      s_rdata,
    input  logic                        s_ack,
    input  logic                        s_decode,
    output xbus_state_e                 state_dbg
);

    localparam int               IDX_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [TMO_W-1:0] TMO_TERM = TMO_W'(tmo_term(TMO_W));
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NREQ - 1);
    localparam logic [2:0]       MISS_LIM = 3'(DECODE_MISS_LIMIT);

    xbus_state_e state, state_nxt;

    logic [IDX_W-1:0]       last;
    logic [TMO_W-1:0]       cnt;
    logic [2:0]             miss_run;
    logic [NREQ-1:0]        pick;
    logic [XBUS_ADDR_W-1:0] pick_addr;
    logic [XBUS_DATA_W-1:0] pick_wdata;
    logic                   pick_write;
    logic [IDX_W-1:0]       grant_idx;
    logic                   owner_req;
    logic                   abort;
    logic                   done_ack;
    logic                   done_tmo;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req  (m_req),
        .last (last),
        .gnt  (pick)
    );

    // Latch source for the winner, and the owner index recorded as `last`.
    always_comb begin
        pick_addr  = '0;
        pick_wdata = '0;
        pick_write = 1'b0;
        grant_idx  = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (pick[j]) begin
                pick_addr  = m_addr[j*XBUS_ADDR_W +: XBUS_ADDR_W];
                pick_wdata = m_wdata[j*XBUS_DATA_W +: XBUS_DATA_W];
                pick_write = m_write[j];
            end
            if (grant[j]) begin
                grant_idx = IDX_W'(j);
            end
        end
    end

    // Abort beats completion: a master that has withdrawn gets no ack.
    // s_ack beats the timeout when both land in the same cycle.
    always_comb begin
        owner_req = |(m_req & grant);
        abort     = (state == REQ) && !owner_req;
        done_ack  = (state == REQ) && owner_req && s_ack;
        done_tmo  = (state == REQ) && owner_req && !s_ack && (cnt == TMO_TERM);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (|m_req) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (done_ack || done_tmo) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (!owner_req) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant      <= '0;
            last       <= LAST_RST;
            cnt        <= '0;
            miss_run   <= '0;
            s_addr     <= '0;
            s_write    <= 1'b0;
            s_wdata    <= '0;
            m_rdata    <= '0;
            m_timedout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|m_req) begin
                        grant    <= pick;
                        s_addr   <= pick_addr;
                        s_write  <= pick_write;
                        s_wdata  <= pick_wdata;
                        cnt      <= '0;
                        miss_run <= '0;
                    end
                end
                REQ: begin
                    if (abort) begin
                        grant    <= '0;
                        cnt      <= '0;
                        miss_run <= '0;
                    end else if (done_ack) begin
                        if (!s_write) begin
                            m_rdata <= s_rdata;
                        end
                        m_timedout <= 1'b0;
                    end else if (done_tmo) begin
                        if (!s_write) begin
                            m_rdata <= '0;
                        end
                        m_timedout <= 1'b1;
                    end else begin
                        // Once the slave has left the address unclaimed for
                        // the full miss window, jump to the terminal count so
                        // the access times out on the following cycle.
                        if (miss_run == MISS_LIM) begin
                            cnt <= TMO_TERM;
                        end else begin
                            cnt <= cnt + TMO_W'(1);
                        end
                        if (s_decode) begin
                            miss_run <= '0;
                        end else if (miss_run != MISS_LIM) begin
                            miss_run <= miss_run + 3'd1;
                        end
                    end
                end
                WAIT: begin
                    if (!owner_req) begin
                        last     <= grant_idx;
                        grant    <= '0;
                        cnt      <= '0;
                        miss_run <= '0;
                    end
                end
                default: begin
                    grant <= '0;
                end
            endcase
        end
    end

    assign s_req     = (state == REQ);
    assign m_ack     = (state == WAIT) ? grant : '0;
    assign state_dbg = state;

endmodule

// File: tb/tb_xbus_arbiter.sv
module tb_xbus_arbiter;
    import xbus_pkg::*;

    localparam int NREQ  = 3;
    localparam int TMO_W = 6;
    localparam int TERM  = (1 << TMO_W) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic [NREQ-1:0]    m_req;
    logic [NREQ-1:0]    m_write;
    logic [NREQ*22-1:0] m_addr;
    logic [NREQ*32-1:0] m_wdata;
    logic [NREQ-1:0]    m_ack;
    logic               m_timedout;
    logic [31:0]        m_rdata;
    logic [NREQ-1:0]    grant;
    logic               s_req;
    logic               s_write;
    logic [21:0]        s_addr;
    logic [31:0]        s_wdata;
    logic [31:0]        s_rdata;
    logic               s_ack;
    logic               s_decode;
    xbus_state_e        state_dbg;

    xbus_arbiter #(.NREQ(NREQ), .TMO_W(TMO_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .m_req      (m_req),
        .m_write    (m_write),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_ack      (m_ack),
        .m_timedout (m_timedout),
        .m_rdata    (m_rdata),
        .grant      (grant),
        .s_req      (s_req),
        .s_write    (s_write),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_rdata    (s_rdata),
        .s_ack      (s_ack),
        .s_decode   (s_decode),
        .state_dbg  (state_dbg)
    );

    int total = 0;
    int bad   = 0;
    logic [NREQ-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    // Owner is an index (-1 = nobody); done marks the acknowledged phase.
    int          mo_owner = -1;
    bit          mo_done  = 1'b0;
    int          mo_cnt   = 0;
    int          mo_miss  = 0;
    int          mo_last  = NREQ - 1;
    bit          mo_wr    = 1'b0;
    logic [21:0] mo_addr  = '0;
    logic [31:0] mo_wdata = '0;
    logic [31:0] mo_rdata = '0;
    bit          mo_to    = 1'b0;

    function automatic bit bit_at(input logic [NREQ-1:0] v, input int i);
        return ((v >> i) & NREQ'(1)) != '0;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mo_owner = -1; mo_done = 1'b0; mo_cnt = 0; mo_miss = 0;
            mo_last = NREQ - 1; mo_wr = 1'b0; mo_addr = '0; mo_wdata = '0;
            mo_rdata = '0; mo_to = 1'b0;
        end else if (mo_owner < 0) begin
            if (m_req != '0) begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (mo_owner < 0 && bit_at(m_req, (mo_last + k) % NREQ))
                        mo_owner = (mo_last + k) % NREQ;
                end
                mo_done  = 1'b0;
                mo_cnt   = 0;
                mo_miss  = 0;
                mo_wr    = bit_at(m_write, mo_owner);
                mo_addr  = 22'(m_addr >> (mo_owner * 22));
                mo_wdata = 32'(m_wdata >> (mo_owner * 32));
            end
        end else if (!mo_done) begin
            if (!bit_at(m_req, mo_owner)) begin
                mo_owner = -1;
            end else if (s_ack) begin
                mo_done = 1'b1;
                if (!mo_wr) mo_rdata = s_rdata;
                mo_to = 1'b0;
            end else if (mo_cnt == TERM) begin
                mo_done = 1'b1;
                if (!mo_wr) mo_rdata = '0;
                mo_to = 1'b1;
            end else begin
                mo_cnt  = (mo_miss >= 4) ? TERM : mo_cnt + 1;
                mo_miss = s_decode ? 0 : mo_miss + 1;
            end
        end else if (!bit_at(m_req, mo_owner)) begin
            mo_last  = mo_owner;
            mo_owner = -1;
        end
    end

    // Every-cycle comparison on the falling edge.
    always @(negedge clk) begin
        logic [NREQ-1:0] eg, ea;
        bit es;
        if (reset_n === 1'b1) begin
            eg = (mo_owner >= 0) ? (NREQ'(1) << mo_owner) : '0;
            es = (mo_owner >= 0) && !mo_done;
            ea = (mo_owner >= 0 && mo_done) ? eg : '0;
            chk("grant", 32'(grant), 32'(eg));
            chk("s_req", 32'(s_req), 32'(es));
            chk("m_ack", 32'(m_ack), 32'(ea));
            chk("m_rdata", m_rdata, mo_rdata);
            if (es) begin
                chk("s_addr", 32'(s_addr), 32'(mo_addr));
                chk("s_write", 32'(s_write), 32'(mo_wr));
                chk("s_wdata", s_wdata, mo_wdata);
            end
            if (ea != '0) chk("m_timedout", 32'(m_timedout), 32'(mo_to));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        while (m_ack == '0 && n < 300) begin
            tick();
            n++;
        end
    endtask

    task automatic do_reset();
        m_req = '0; s_ack = 1'b0;
        reset_n = 1'b0;
        #12;
        reset_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int n;
        int got;
        logic [NREQ-1:0] prev_g;
        logic [NREQ-1:0] e;

        reset_n = 1'b0;
        m_req = '0; m_write = '0; m_addr = '0; m_wdata = '0;
        s_rdata = '0; s_ack = 1'b0; s_decode = 1'b1;
        #23;
        reset_n = 1'b1;
        #1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_m_ack", 32'(m_ack), 32'h0);
        chk("rst_s_req", 32'(s_req), 32'h0);
        chk("rst_m_rdata", m_rdata, 32'h0);
        chk("rst_m_timedout", 32'(m_timedout), 32'h0);
        chk("rst_s_addr", 32'(s_addr), 32'h0);
        chk("rst_state", 32'(state_dbg), 32'(IDLE));

        // Single read by master 1, slave acks in its third REQ cycle.
        m_req[1] = 1'b1; m_write[1] = 1'b0; m_addr[22 +: 22] = 22'h001234;
        tick();
        chk("t1_grant", 32'(grant), 32'h2);
        chk("t1_s_req", 32'(s_req), 32'h1);
        chk("t1_s_addr", 32'(s_addr), 32'h001234);
        tick(); tick();
        s_ack = 1'b1; s_rdata = 32'hDEADBEEF;
        tick();
        chk("t1_m_ack", 32'(m_ack), 32'h2);
        chk("t1_m_rdata", m_rdata, 32'hDEADBEEF);
        chk("t1_m_timedout", 32'(m_timedout), 32'h0);
        s_ack = 1'b0; m_req[1] = 1'b0;
        tick();
        chk("t1_grant_idle", 32'(grant), 32'h0);
        chk("t1_m_ack_idle", 32'(m_ack), 32'h0);

        // All three masters request continuously from reset.
        do_reset();
        for (int k = 0; k < 6; k++) exp_q.push_back(NREQ'(1) << (k % NREQ));
        m_write = '0;
        m_req = '1;
        prev_g = '0;
        got = 0;
        for (int c = 0; c < 100 && got < 6; c++) begin
            tick();
            if (grant != '0 && prev_g == '0) begin
                e = exp_q.pop_front();
                chk("rr_order", 32'(grant), 32'(e));
                got++;
            end
            if (grant == '0) chk("idle_no_s_req", 32'(s_req), 32'h0);
            prev_g = grant;
            s_ack = s_req;
            s_rdata = $urandom | 32'h1;
            for (int i = 0; i < NREQ; i++) m_req[i] = !m_ack[i];
        end
        chk("rr_count", 32'(got), 32'd6);
        m_req = '0; s_ack = 1'b0;
        for (int c = 0; c < 10 && grant != '0; c++) tick();
        tick();

        // Full timeout, slave claims the address.
        s_decode = 1'b1;
        m_req[0] = 1'b1; m_write[0] = 1'b0;
        tick();
        wait_ack(n);
        chk("tmo_cycles", 32'(n), 32'd64);
        chk("tmo_m_rdata", m_rdata, 32'h0);
        chk("tmo_m_timedout", 32'(m_timedout), 32'h1);
        m_req[0] = 1'b0;
        tick();

        // Unclaimed address times out early.
        s_decode = 1'b0;
        m_req[0] = 1'b1;
        tick();
        wait_ack(n);
        chk("nodec_cycles", 32'(n), 32'd6);
        chk("nodec_m_timedout", 32'(m_timedout), 32'h1);
        m_req[0] = 1'b0; s_decode = 1'b1;
        tick();

        // s_ack lands on the terminal count.
        m_req[0] = 1'b1;
        tick();
        repeat (TERM) tick();
        s_ack = 1'b1; s_rdata = 32'h5A5A5A5A;
        tick();
        chk("tie_m_ack", 32'(m_ack), 32'h1);
        chk("tie_m_rdata", m_rdata, 32'h5A5A5A5A);
        chk("tie_m_timedout", 32'(m_timedout), 32'h0);
        s_ack = 1'b0; m_req[0] = 1'b0;
        tick();

        // Abort by master 2; last stays at master 0.
        m_req[2] = 1'b1; m_write[2] = 1'b0;
        tick();
        chk("abort_grant", 32'(grant), 32'h4);
        tick();
        m_req[2] = 1'b0;
        tick();
        chk("abort_state", 32'(state_dbg), 32'(IDLE));
        chk("abort_grant_idle", 32'(grant), 32'h0);
        chk("abort_no_ack", 32'(m_ack), 32'h0);
        m_req[0] = 1'b1; m_req[1] = 1'b1; m_write[1:0] = 2'b00;
        tick();
        chk("abort_next_pick", 32'(grant), 32'h2);
        s_ack = 1'b1; s_rdata = 32'hCAFEF00D;
        tick();
        chk("abort_next_ack", 32'(m_ack), 32'h2);
        s_ack = 1'b0; m_req[1] = 1'b0;
        tick();
        tick();
        chk("rst_mid_grant_before", 32'(grant), 32'h1);

        // Asynchronous reset in the middle of REQ, away from any edge.
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_s_req", 32'(s_req), 32'h0);
        chk("arst_grant", 32'(grant), 32'h0);
        chk("arst_m_ack", 32'(m_ack), 32'h0);
        chk("arst_m_rdata", m_rdata, 32'h0);
        chk("arst_state", 32'(state_dbg), 32'(IDLE));
        m_req = '0;
        #3;
        reset_n = 1'b1;
        tick();

        // Randomised traffic checked every cycle by the reference.
        for (int seg = 0; seg < 3; seg++) begin
            int ack_div, dec_div;
            ack_div = (seg == 0) ? 2 : (seg == 1) ? 40 : 200;
            dec_div = (seg == 0) ? 15 : (seg == 1) ? 1 : 40;
            for (int c = 0; c < 1500; c++) begin
                tick();
                for (int i = 0; i < NREQ; i++) begin
                    if (m_req[i]) begin
                        if (m_ack[i]) m_req[i] = 1'b0;
                        else if (grant[i] && s_req && $urandom_range(0, 49) == 0) m_req[i] = 1'b0;
                    end else if ($urandom_range(0, 3) == 0) begin
                        m_req[i] = 1'b1;
                        m_write[i] = 1'($urandom_range(0, 1));
                        m_addr[i*22 +: 22] = 22'($urandom);
                        m_wdata[i*32 +: 32] = $urandom;
                    end
                end
                s_ack = s_req ? ($urandom_range(0, ack_div) == 0) : ($urandom_range(0, 3) == 0);
                s_decode = ($urandom_range(0, dec_div) != 0);
                s_rdata = $urandom;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
